// File: rtl/fp_round_pipe.sv
// ---------------------------------------------------------------------------
// fp_round_pipe
//   Two-stage pipelined floating-point rounding stage for the add/sub
//   datapath, sitting between normalize and pack.
//
//   Stage 1 decides round-up from the round mode, sign, R/S bits and mantissa
//   LSB, and registers the incremented mantissa (one carry bit wide).
//   Stage 2 folds the mantissa carry into the exponent, detects overflow and
//   substitutes either infinity or the largest finite value depending on the
//   round direction.
//
//   Parameters
//     EXP_W  exponent field width (in_e/out_e are EXP_W+1 bits wide)
//     MAN_W  stored mantissa width, hidden bit excluded
//     TAG_W  width of the opaque tag carried with each op
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     in_valid/in_ready   upstream handshake
//     in_sgn/e/m/r/s      normalized operand with round and sticky bits
//     in_mode             00 RNE, 01 toward +inf, 10 toward zero, 11 toward -inf
//     in_tag              passed through unchanged
//     out_valid/out_ready downstream handshake
//     out_sgn/e/m/tag     rounded result
//     out_inexact         R|S, or overflow
//     out_ovf             rounded exponent reached all-ones
//     flag_clr            clears the accumulated flags
//     sticky_inexact/ovf  accumulated flags
//
//   Build option
//     FP_ROUND_STICKY_FLAGS_EN  when defined, sticky_inexact/sticky_ovf
//     accumulate the flags of every transferred result; otherwise they are
//     tied low and flag_clr is ignored.
// ---------------------------------------------------------------------------
module fp_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sgn,
    input  logic [EXP_W:0]   in_e,
    input  logic [MAN_W-1:0] in_m,
    input  logic             in_r,
    input  logic             in_s,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sgn,
    output logic [EXP_W:0]   out_e,
    output logic [MAN_W-1:0] out_m,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_inexact,
    output logic             out_ovf,
    input  logic             flag_clr,
    output logic             sticky_inexact,
    output logic             sticky_ovf
);

    localparam logic [EXP_W:0] E_MAX_EXP = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] E_MAX_FIN = E_MAX_EXP - 1'b1;

    // Stage 1 registers
    logic             s1_valid_q,   s1_valid_d;
    logic             s1_sgn_q,     s1_sgn_d;
    logic [EXP_W:0]   s1_e_q,       s1_e_d;
    logic [MAN_W:0]   s1_m_sum_q,   s1_m_sum_d;
    logic [1:0]       s1_mode_q,    s1_mode_d;
    logic             s1_inexact_q, s1_inexact_d;
    logic [TAG_W-1:0] s1_tag_q,     s1_tag_d;

    // Stage 2 (output) registers
    logic             s2_valid_q,    s2_valid_d;
    logic             out_sgn_q,     out_sgn_d;
    logic [EXP_W:0]   out_e_q,       out_e_d;
    logic [MAN_W-1:0] out_m_q,       out_m_d;
    logic [TAG_W-1:0] out_tag_q,     out_tag_d;
    logic             out_inexact_q, out_inexact_d;
    logic             out_ovf_q,     out_ovf_d;

    logic             adv1, adv2;
    logic             up;
    logic             carry;
    logic [EXP_W:0]   e_rnd;
    logic [MAN_W-1:0] m_rnd;
    logic             ovf;
    logic             to_inf;

    // Each stage advances when it is empty or the stage after it moves.
    always_comb begin
        adv2     = ~s2_valid_q | out_ready;
        adv1     = ~s1_valid_q | adv2;
        in_ready = adv1;
    end

    // Stage 1: round-up decision and mantissa increment
    always_comb begin
        unique case (in_mode)
            2'b00:   up = in_r & (in_s | in_m[0]);
            2'b01:   up = (in_r | in_s) & ~in_sgn;
            2'b10:   up = 1'b0;
            default: up = (in_r | in_s) & in_sgn;
        endcase

        s1_valid_d   = adv1 ? in_valid : s1_valid_q;
        s1_sgn_d     = s1_sgn_q;
        s1_e_d       = s1_e_q;
        s1_m_sum_d   = s1_m_sum_q;
        s1_mode_d    = s1_mode_q;
        s1_inexact_d = s1_inexact_q;
        s1_tag_d     = s1_tag_q;
        if (adv1 && in_valid) begin
            s1_sgn_d     = in_sgn;
            s1_e_d       = in_e;
            s1_m_sum_d   = {1'b0, in_m} + {{MAN_W{1'b0}}, up};
            s1_mode_d    = in_mode;
            s1_inexact_d = in_r | in_s;
            s1_tag_d     = in_tag;
        end
    end

    // Stage 2: carry into exponent, overflow substitution
    always_comb begin
        carry  = s1_m_sum_q[MAN_W];
        e_rnd  = s1_e_q + {{EXP_W{1'b0}}, carry};
        m_rnd  = carry ? '0 : s1_m_sum_q[MAN_W-1:0];
        ovf    = e_rnd[EXP_W] | (&e_rnd[EXP_W-1:0]);
        to_inf = (s1_mode_q == 2'b00)
               | ((s1_mode_q == 2'b01) & ~s1_sgn_q)
               | ((s1_mode_q == 2'b11) &  s1_sgn_q);

        s2_valid_d    = adv2 ? s1_valid_q : s2_valid_q;
        out_sgn_d     = out_sgn_q;
        out_e_d       = out_e_q;
        out_m_d       = out_m_q;
        out_tag_d     = out_tag_q;
        out_inexact_d = out_inexact_q;
        out_ovf_d     = out_ovf_q;
        if (adv2 && s1_valid_q) begin
            out_sgn_d     = s1_sgn_q;
            out_tag_d     = s1_tag_q;
            out_ovf_d     = ovf;
            out_inexact_d = s1_inexact_q | ovf;
            if (!ovf) begin
                out_e_d = e_rnd;
                out_m_d = m_rnd;
            end else if (to_inf) begin
                out_e_d = E_MAX_EXP;
                out_m_d = '0;
            end else begin
                out_e_d = E_MAX_FIN;
                out_m_d = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_sgn_q      <= 1'b0;
            s1_e_q        <= '0;
            s1_m_sum_q    <= '0;
            s1_mode_q     <= '0;
            s1_inexact_q  <= 1'b0;
            s1_tag_q      <= '0;
            s2_valid_q    <= 1'b0;
            out_sgn_q     <= 1'b0;
            out_e_q       <= '0;
            out_m_q       <= '0;
            out_tag_q     <= '0;
            out_inexact_q <= 1'b0;
            out_ovf_q     <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sgn_q      <= s1_sgn_d;
            s1_e_q        <= s1_e_d;
            s1_m_sum_q    <= s1_m_sum_d;
            s1_mode_q     <= s1_mode_d;
            s1_inexact_q  <= s1_inexact_d;
            s1_tag_q      <= s1_tag_d;
            s2_valid_q    <= s2_valid_d;
            out_sgn_q     <= out_sgn_d;
            out_e_q       <= out_e_d;
            out_m_q       <= out_m_d;
            out_tag_q     <= out_tag_d;
            out_inexact_q <= out_inexact_d;
            out_ovf_q     <= out_ovf_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_sgn     = out_sgn_q;
    assign out_e       = out_e_q;
    assign out_m       = out_m_q;
    assign out_tag     = out_tag_q;
    assign out_inexact = out_inexact_q;
    assign out_ovf     = out_ovf_q;

`ifdef FP_ROUND_STICKY_FLAGS_EN
    logic sticky_inexact_q, sticky_inexact_d;
    logic sticky_ovf_q,     sticky_ovf_d;
    logic out_xfer;

    // A flag arriving with a transfer overrides a simultaneous clear.
    always_comb begin
        out_xfer         = s2_valid_q & out_ready;
        sticky_inexact_d = (flag_clr ? 1'b0 : sticky_inexact_q) | (out_xfer & out_inexact_q);
        sticky_ovf_d     = (flag_clr ? 1'b0 : sticky_ovf_q)     | (out_xfer & out_ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_inexact_q <= 1'b0;
            sticky_ovf_q     <= 1'b0;
        end else begin
            sticky_inexact_q <= sticky_inexact_d;
            sticky_ovf_q     <= sticky_ovf_d;
        end
    end

    assign sticky_inexact = sticky_inexact_q;
    assign sticky_ovf     = sticky_ovf_q;
`else
    logic unused_flag_clr;
    assign unused_flag_clr = flag_clr;
    assign sticky_inexact  = 1'b0;
    assign sticky_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_fp_round_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_round_pipe
//   Scoreboard bench for fp_round_pipe (EXP_W=8, MAN_W=23, TAG_W=4).
//   Expected results are computed by a reference model when an op is
//   accepted and compared when the DUT transfers a result.
// ---------------------------------------------------------------------------
module tb_fp_round_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic             sgn;
        logic [EXP_W:0]   e;
        logic [MAN_W-1:0] m;
        logic [TAG_W-1:0] tag;
        logic             inx;
        logic             ovf;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sgn = 1'b0;
    logic [EXP_W:0]   in_e = '0;
    logic [MAN_W-1:0] in_m = '0;
    logic             in_r = 1'b0;
    logic             in_s = 1'b0;
    logic [1:0]       in_mode = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_sgn;
    logic [EXP_W:0]   out_e;
    logic [MAN_W-1:0] out_m;
    logic [TAG_W-1:0] out_tag;
    logic             out_inexact;
    logic             out_ovf;
    logic             flag_clr = 1'b0;
    logic             sticky_inexact;
    logic             sticky_ovf;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t sb[$];

    fp_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sgn(in_sgn), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_s(in_s),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sgn(out_sgn), .out_e(out_e), .out_m(out_m), .out_tag(out_tag),
        .out_inexact(out_inexact), .out_ovf(out_ovf),
        .flag_clr(flag_clr), .sticky_inexact(sticky_inexact), .sticky_ovf(sticky_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic sgn, input logic [EXP_W:0] e,
                                   input logic [MAN_W-1:0] m, input logic r, input logic s,
                                   input logic [1:0] mode, input logic [TAG_W-1:0] tag);
        res_t            x;
        logic            up;
        longint unsigned sig;
        int unsigned     ex;
        logic            to_inf;
        case (mode)
            2'd0:    up = r & (s | m[0]);
            2'd1:    up = (r | s) & ~sgn;
            2'd2:    up = 1'b0;
            default: up = (r | s) & sgn;
        endcase
        sig = longint'(m) + longint'(up);
        ex  = int'(e);
        if (sig == (64'd1 << MAN_W)) begin
            sig = 0;
            ex  = (ex + 1) % (1 << (EXP_W + 1));
        end
        x.sgn = sgn;
        x.tag = tag;
        x.inx = r | s;
        x.ovf = (ex >= (1 << EXP_W) - 1);
        if (x.ovf) begin
            x.inx  = 1'b1;
            to_inf = (mode == 2'd0) || (mode == 2'd1 && !sgn) || (mode == 2'd3 && sgn);
            if (to_inf) begin
                x.e = (EXP_W+1)'((1 << EXP_W) - 1);
                x.m = '0;
            end else begin
                x.e = (EXP_W+1)'((1 << EXP_W) - 2);
                x.m = '1;
            end
        end else begin
            x.e = ex[EXP_W:0];
            x.m = sig[MAN_W-1:0];
        end
        return x;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic sgn, input logic [EXP_W:0] e, input logic [MAN_W-1:0] m,
                        input logic r, input logic s, input logic [1:0] mode,
                        input logic [TAG_W-1:0] tag);
        bit done = 1'b0;
        in_sgn = sgn; in_e = e; in_m = m; in_r = r; in_s = s; in_mode = mode; in_tag = tag;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(sgn, e, m, r, s, mode, tag));
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", 64'(done), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0) ok = 1'b1;
        end
        if (!ok) check("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Output monitor: compare on transfer, check stability while stalled.
    always @(negedge clk) begin
        res_t got;
        res_t exp_r;
        if (!rst && out_valid) begin
            got = '{sgn: out_sgn, e: out_e, m: out_m, tag: out_tag, inx: out_inexact, ovf: out_ovf};
            if (sb.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else if (out_ready) begin
                exp_r = sb.pop_front();
                check("result", 64'(got), 64'(exp_r));
            end else begin
                check("hold", 64'(got), 64'(sb[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MAN_W-1:0] rm;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'({out_sgn, out_e, out_m, out_tag, out_inexact, out_ovf}), 64'd0);
        check("rst_sticky", 64'({sticky_inexact, sticky_ovf}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency: accepted op is in stage 1, visible one edge later
        send(1'b0, 9'h080, 23'h000001, 1'b1, 1'b0, 2'b00, 4'd1);
        check("lat_s1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_s2", 64'(out_valid), 64'd1);

        // Directed rounding cases, back to back
        send(1'b0, 9'h080, 23'h000002, 1'b1, 1'b0, 2'b00, 4'd2);
        send(1'b0, 9'h080, 23'h7FFFFF, 1'b1, 1'b1, 2'b00, 4'd3);
        send(1'b0, 9'h080, 23'h7FFFFF, 1'b1, 1'b1, 2'b10, 4'd4);
        send(1'b0, 9'h0FE, 23'h7FFFFF, 1'b1, 1'b0, 2'b00, 4'd5);
        send(1'b0, 9'h0FE, 23'h7FFFFF, 1'b1, 1'b0, 2'b11, 4'd6);
        send(1'b1, 9'h0FE, 23'h7FFFFF, 1'b0, 1'b1, 2'b11, 4'd7);
        send(1'b1, 9'h0FE, 23'h7FFFFF, 1'b0, 1'b1, 2'b01, 4'd8);
        send(1'b0, 9'h040, 23'h123456, 1'b0, 1'b1, 2'b01, 4'd9);
        send(1'b1, 9'h040, 23'h123456, 1'b0, 1'b0, 2'b00, 4'd10);
        send(1'b0, 9'h000, 23'h7FFFFF, 1'b1, 1'b1, 2'b00, 4'd11);
        send(1'b0, 9'h0FF, 23'h000000, 1'b0, 1'b0, 2'b00, 4'd12);
        send(1'b0, 9'h1FF, 23'h7FFFFF, 1'b1, 1'b1, 2'b00, 4'd13);
        send(1'b0, 9'h0FF, 23'h000000, 1'b0, 1'b0, 2'b10, 4'd14);
        drain();

        // Backpressure: two ops fill the pipe, then a 4-cycle burst
        out_ready = 1'b0;
        fork
            begin
                for (int t = 1; t <= 4; t++)
                    send(1'b0, 9'h020, 23'(t * 3), 1'b0, 1'b1, 2'b00, 4'(t));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_accepted", 64'(sb.size()), 64'd2);
                out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_burst", 64'(out_valid), 64'd1);
                end
            end
        join
        drain();

        // Reset with two ops in flight
        out_ready = 1'b0;
        send(1'b0, 9'h050, 23'h000111, 1'b1, 1'b1, 2'b00, 4'd9);
        send(1'b0, 9'h050, 23'h000222, 1'b1, 1'b1, 2'b00, 4'd10);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

`ifdef FP_ROUND_STICKY_FLAGS_EN
        check("stk_after_rst", 64'({sticky_inexact, sticky_ovf}), 64'd0);
        send(1'b0, 9'h0FE, 23'h7FFFFF, 1'b1, 1'b0, 2'b00, 4'd1);
        for (int t = 2; t <= 4; t++)
            send(1'b0, 9'h010, 23'(t), 1'b0, 1'b0, 2'b00, 4'(t));
        drain();
        check("stk_set", 64'({sticky_inexact, sticky_ovf}), 64'b11);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        check("stk_clr", 64'({sticky_inexact, sticky_ovf}), 64'd0);
        // Clear and set on the same edge: set wins
        out_ready = 1'b0;
        send(1'b0, 9'h010, 23'h000004, 1'b0, 1'b1, 2'b10, 4'd5);
        @(posedge clk); #1;
        flag_clr  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flag_clr  = 1'b0;
        check("stk_set_wins", 64'({sticky_inexact, sticky_ovf}), 64'b10);
`else
        send(1'b0, 9'h0FE, 23'h7FFFFF, 1'b1, 1'b0, 2'b00, 4'd1);
        drain();
        check("stk_tied", 64'({sticky_inexact, sticky_ovf}), 64'd0);
`endif

        // Random ops under random backpressure
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    rm = ($urandom_range(0, 3) == 0) ? '1 : MAN_W'($urandom);
                    send(1'($urandom), 9'($urandom_range(0, 511)), rm,
                         1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
                end
            end
            begin
                repeat (400) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
